// File: rtl/dm_uncache_unit.sv
// Uncached data-side access engine: turns one uncached load/store into a
// single-beat read or write on the shared cache/bus request interface.
module dm_uncache_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        op,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data,
  output logic        wr_req,
  output logic [2:0]  wr_type,
  output logic [31:0] wr_addr,
  output logic [3:0]  wr_wstrb,
  output logic [31:0] wr_data,
  input  logic        wr_rdy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [31:0] rdata_q;

  logic accept;
  assign accept = (state_q == S_IDLE) && valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (valid) state_d = op ? S_WR_REQ : S_RD_REQ;
      S_RD_REQ:  if (rd_rdy) state_d = S_RD_WAIT;
      S_RD_WAIT: if (ret_valid && ret_last) state_d = S_DONE;
      S_WR_REQ:  if (wr_rdy) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request fields are frozen at accept so bus outputs hold until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_size  <= 2'b00;
      req_addr  <= 32'h0;
      req_wstrb <= 4'h0;
      req_wdata <= 32'h0;
    end else if (accept) begin
      req_size  <= size;
      req_addr  <= addr;
      req_wstrb <= wstrb;
      req_wdata <= wdata;
    end
  end

  // Only beats seen while waiting for a read return may touch rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  rdata_q <= 32'h0;
    else if (state_q == S_RD_WAIT && ret_valid) rdata_q <= ret_data;
  end

  assign data_ok  = (state_q == S_DONE);
  assign rdata    = rdata_q;
  assign rd_req   = (state_q == S_RD_REQ);
  assign rd_type  = {1'b0, req_size};
  assign rd_addr  = req_addr;
  assign wr_req   = (state_q == S_WR_REQ);
  assign wr_type  = {1'b0, req_size};
  assign wr_addr  = req_addr;
  assign wr_wstrb = req_wstrb;
  assign wr_data  = req_wdata;

endmodule
